// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that streams operand bits, LSB first, through a single-bit full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next, sum_q;
    logic             carry_q, c_out_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder u_fa (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the first sum bit.
    assign res_next = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= c_in;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CNT_W'(1);
                    // Published results only move on the final bit so they hold between operations.
                    if (last_bit) begin
                        sum_q   <= res_next;
                        c_out_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= carry_q ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// Covers SERIAL_ADDER_OVF_EN when that macro is defined for the whole build.

module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] prev_sum;
    logic       prev_cout;
    logic [7:0] ka [30];
    logic [7:0] kb [30];
    logic       kc [30];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf1)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic signed_ovf8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int s;
        s = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        return (s > 127) || (s < -128);
    endfunction

    // Called at a falling edge with the DUT idle; returns one cycle after done, DUT idle again.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] total;
        total  = 9'(av) + 9'(bv) + 9'(cv);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check_output("sum_held", 32'(sum8), 32'(prev_sum));
        check_output("cout_held", 32'(cout8), 32'(prev_cout));
        for (int i = 0; i < 8; i++) begin
            check_output("busy_shift", 32'(busy8), 32'd1);
            check_output("done_shift", 32'(done8), 32'd0);
            @(negedge clk);
        end
        check_output("done_pulse", 32'(done8), 32'd1);
        check_output("busy_done", 32'(busy8), 32'd0);
        check_output("sum", 32'(sum8), 32'(total[7:0]));
        check_output("c_out", 32'(cout8), 32'(total[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check_output("ovf", 32'(ovf8), 32'(signed_ovf8(av, bv, cv)));
`endif
        prev_sum  = total[7:0];
        prev_cout = total[8];
        @(negedge clk);
        check_output("done_drop", 32'(done8), 32'd0);
        check_output("busy_idle", 32'(busy8), 32'd0);
    endtask

    task automatic run_width1(input logic av, input logic bv, input logic cv);
        logic [1:0] total;
        total  = 2'(av) + 2'(bv) + 2'(cv);
        start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
        @(negedge clk);
        start1 = 1'b0;
        check_output("w1_busy", 32'(busy1), 32'd1);
        check_output("w1_done_early", 32'(done1), 32'd0);
        @(negedge clk);
        check_output("w1_done", 32'(done1), 32'd1);
        check_output("w1_result", 32'({cout1, sum1}), 32'(total));
        @(negedge clk);
        check_output("w1_done_drop", 32'(done1), 32'd0);
    endtask

    initial begin
        int         done_seen;
        logic [8:0] total;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy8), 32'd0);
        check_output("rst_done", 32'(done8), 32'd0);
        check_output("rst_sum", 32'(sum8), 32'd0);
        check_output("rst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_output("rst_ovf", 32'(ovf8), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] WIDTH=1 exhaustive");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_width1(v[2], v[1], v[0]);
        end

        $display("[TB] WIDTH=8 directed and random operations");
        apply_stimulus(8'hFF, 8'h01, 1'b0);
        apply_stimulus(8'hA5, 8'h5A, 1'b1);
        apply_stimulus(8'h12, 8'h34, 1'b0);
        apply_stimulus(8'h7F, 8'h01, 1'b0);
        apply_stimulus(8'h80, 8'h80, 1'b1);
        for (int i = 0; i < 10; i++)
            apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));

        $display("[TB] start held high with changing operands");
        for (int k = 0; k < 30; k++) begin
            ka[k] = 8'($urandom); kb[k] = 8'($urandom); kc[k] = 1'($urandom);
            start8 = 1'b1; a8 = ka[k]; b8 = kb[k]; cin8 = kc[k];
            @(negedge clk);
            if (k % 10 < 8) begin
                check_output("held_busy", 32'(busy8), 32'd1);
                check_output("held_done_low", 32'(done8), 32'd0);
            end else if (k % 10 == 8) begin
                total = 9'(ka[k-8]) + 9'(kb[k-8]) + 9'(kc[k-8]);
                check_output("held_done", 32'(done8), 32'd1);
                check_output("held_result", 32'({cout8, sum8}), 32'(total));
                prev_sum = total[7:0]; prev_cout = total[8];
            end else begin
                check_output("held_idle_busy", 32'(busy8), 32'd0);
                check_output("held_idle_done", 32'(done8), 32'd0);
            end
        end
        start8 = 1'b0;
        @(negedge clk);

        $display("[TB] reset during an operation");
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h4D; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy8), 32'd0);
        check_output("abort_done", 32'(done8), 32'd0);
        check_output("abort_sum", 32'(sum8), 32'd0);
        check_output("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check_output("abort_no_done", 32'(done_seen), 32'd0);
        prev_sum = 8'h00; prev_cout = 1'b0;
        apply_stimulus(8'h3C, 8'h4D, 1'b1);
        apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
